frg1_activity_monitor: RTL and testbench

FRG1_ACTIVITY_MONITOR -- requirements
Module: frg1_activity_monitor

---
 rtl/frg1_activity_monitor.sv | 158 +++++++++++++++
 tb/tb_frg1_activity_monitor.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frg1_activity_monitor.sv
// frg1_activity_monitor: counts per-output toggles of frg1's d0/e0/f0 over a window of valid samples.
// Optional macro TOGGLE_SAT_EN: counters saturate at all-ones and a sat_flag output is added.
module frg1_activity_monitor #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic             sample_vld,
  input  logic             d0,
  input  logic             e0,
  input  logic             f0,
  output logic             busy,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [CNT_W-1:0] tog_d0,
  output logic [CNT_W-1:0] tog_e0,
  output logic [CNT_W-1:0] tog_f0,
  output logic [CNT_W+1:0] tog_total,
`ifdef TOGGLE_SAT_EN
  output logic             sat_flag,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: results are offered with res_vld=1 and are held unchanged until a
  // rising edge sees res_rdy=1; that edge returns the block to IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIN_W-1:0] r_remain;
  logic [2:0]       r_ref;
  logic [CNT_W-1:0] r_tog_d0;
  logic [CNT_W-1:0] r_tog_e0;
  logic [CNT_W-1:0] r_tog_f0;
  logic             r_busy;
  logic             r_res_vld;
  logic [2:0]       w_sample;
  logic [2:0]       w_diff;
  logic [CNT_W-1:0] w_nxt_d0;
  logic [CNT_W-1:0] w_nxt_e0;
  logic [CNT_W-1:0] w_nxt_f0;
`ifdef TOGGLE_SAT_EN
  logic             r_sat;
  logic             w_sat_hit;
`endif

  function automatic logic [CNT_W-1:0] f_bump(input logic [CNT_W-1:0] cnt, input logic hit);
    logic [CNT_W-1:0] v_res;
    v_res = cnt;
`ifdef TOGGLE_SAT_EN
    if (hit && (cnt != {CNT_W{1'b1}})) v_res = cnt + CNT_W'(1);
`else
    if (hit) v_res = cnt + CNT_W'(1);
`endif
    return v_res;
  endfunction

  assign w_sample = {d0, e0, f0};
  assign w_diff   = w_sample ^ r_ref;
  assign w_nxt_d0 = f_bump(r_tog_d0, w_diff[2]);
  assign w_nxt_e0 = f_bump(r_tog_e0, w_diff[1]);
  assign w_nxt_f0 = f_bump(r_tog_f0, w_diff[0]);
`ifdef TOGGLE_SAT_EN
  assign w_sat_hit = (&w_nxt_d0) | (&w_nxt_e0) | (&w_nxt_f0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_remain  <= '0;
      r_ref     <= 3'b000;
      r_tog_d0  <= '0;
      r_tog_e0  <= '0;
      r_tog_f0  <= '0;
      r_busy    <= 1'b0;
      r_res_vld <= 1'b0;
`ifdef TOGGLE_SAT_EN
      r_sat     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_remain <= window_len;
            r_tog_d0 <= '0;
            r_tog_e0 <= '0;
            r_tog_f0 <= '0;
`ifdef TOGGLE_SAT_EN
            r_sat    <= 1'b0;
`endif
            // A zero-length window has nothing to measure and reports at once.
            if (window_len == '0) begin
              r_state   <= S_DONE;
              r_res_vld <= 1'b1;
            end else begin
              r_state <= S_PRIME;
              r_busy  <= 1'b1;
            end
          end
        end
        S_PRIME: begin
          if (sample_vld) begin
            r_ref   <= w_sample;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (sample_vld) begin
            r_tog_d0 <= w_nxt_d0;
            r_tog_e0 <= w_nxt_e0;
            r_tog_f0 <= w_nxt_f0;
            r_ref    <= w_sample;
            r_remain <= r_remain - WIN_W'(1);
`ifdef TOGGLE_SAT_EN
            if (w_sat_hit) r_sat <= 1'b1;
`endif
            if (r_remain == WIN_W'(1)) begin
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_res_vld <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (res_rdy) begin
            r_state   <= S_IDLE;
            r_res_vld <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_res_vld <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign res_vld   = r_res_vld;
  assign tog_d0    = r_tog_d0;
  assign tog_e0    = r_tog_e0;
  assign tog_f0    = r_tog_f0;
  assign tog_total = (CNT_W+2)'(r_tog_d0) + (CNT_W+2)'(r_tog_e0) + (CNT_W+2)'(r_tog_f0);
  assign dbg_state = r_state;
`ifdef TOGGLE_SAT_EN
  assign sat_flag  = r_sat;
`endif

endmodule

// File: tb/tb_frg1_activity_monitor.sv
// Bench for frg1_activity_monitor: a default-width instance and a 2-bit-counter instance share
// one stimulus stream; window results are predicted from the toggle rules on the sample list.
module tb_frg1_activity_monitor;
  localparam int CNT_W  = 16;
  localparam int WIN_W  = 12;
  localparam int CNT_W2 = 2;

  logic clk;
  logic rst;
  logic start;
  logic [WIN_W-1:0] window_len;
  logic sample_vld, d0, e0, f0, res_rdy;
  logic busy, res_vld;
  logic [CNT_W-1:0] tog_d0, tog_e0, tog_f0;
  logic [CNT_W+1:0] tog_total;
  logic [1:0] dbg_state;
  logic busy2, res_vld2;
  logic [CNT_W2-1:0] tog2_d0, tog2_e0, tog2_f0;
  logic [CNT_W2+1:0] tog2_total;
  logic [1:0] dbg_state2;
`ifdef TOGGLE_SAT_EN
  logic sat_flag, sat_flag2;
  bit exp_sat2;
`endif

  int checks;
  int errors;
  logic [3*CNT_W-1:0] exp_q[$];
  logic [2:0] smp_q[$];
  bit vld_q[$];
  int exp_done, exp_tot, exp_tot2;
  logic [3*CNT_W2-1:0] exp_w2;
  int done_j;
  bit busy_seen;

  frg1_activity_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .window_len(window_len), .sample_vld(sample_vld),
    .d0(d0), .e0(e0), .f0(f0), .busy(busy), .res_vld(res_vld), .res_rdy(res_rdy),
    .tog_d0(tog_d0), .tog_e0(tog_e0), .tog_f0(tog_f0), .tog_total(tog_total),
`ifdef TOGGLE_SAT_EN
    .sat_flag(sat_flag),
`endif
    .dbg_state(dbg_state)
  );

  frg1_activity_monitor #(.CNT_W(CNT_W2), .WIN_W(WIN_W)) u_dut_w2 (
    .clk(clk), .rst(rst), .start(start), .window_len(window_len), .sample_vld(sample_vld),
    .d0(d0), .e0(e0), .f0(f0), .busy(busy2), .res_vld(res_vld2), .res_rdy(res_rdy),
    .tog_d0(tog2_d0), .tog_e0(tog2_e0), .tog_f0(tog2_f0), .tog_total(tog2_total),
`ifdef TOGGLE_SAT_EN
    .sat_flag(sat_flag2),
`endif
    .dbg_state(dbg_state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int fold(input int raw, input int w);
    int top;
    top = (1 << w) - 1;
`ifdef TOGGLE_SAT_EN
    return (raw > top) ? top : raw;
`else
    return raw % (1 << w);
`endif
  endfunction

  // Reference model: first valid sample is the reference, then len valid samples are compared.
  task automatic predict(input int len);
    int raw[3];
    int fm[3];
    int f2[3];
    int used;
    bit primed;
    logic [2:0] ref_s;
    logic [2:0] cur;
    raw = '{0, 0, 0};
    used = 0;
    primed = 0;
    ref_s = 3'b000;
    exp_done = (len == 0) ? 0 : -1;
    for (int k = 0; k < smp_q.size(); k++) begin
      if (vld_q[k] && len > 0 && used < len) begin
        cur = smp_q[k];
        if (!primed) primed = 1;
        else begin
          for (int b = 0; b < 3; b++) if (ref_s[2-b] != cur[2-b]) raw[b]++;
          used++;
          if (used == len) exp_done = k + 1;
        end
        ref_s = cur;
      end
    end
    for (int b = 0; b < 3; b++) begin
      fm[b] = fold(raw[b], CNT_W);
      f2[b] = fold(raw[b], CNT_W2);
    end
    exp_q.push_back({CNT_W'(fm[0]), CNT_W'(fm[1]), CNT_W'(fm[2])});
    exp_tot  = fm[0] + fm[1] + fm[2];
    exp_w2   = {CNT_W2'(f2[0]), CNT_W2'(f2[1]), CNT_W2'(f2[2])};
    exp_tot2 = f2[0] + f2[1] + f2[2];
`ifdef TOGGLE_SAT_EN
    exp_sat2 = (raw[0] >= 3) || (raw[1] >= 3) || (raw[2] >= 3);
`endif
  endtask

  task automatic gen_stream(input int len, input int pct);
    int nv;
    int target;
    bit v;
    smp_q.delete();
    vld_q.delete();
    nv = 0;
    target = len + 1 + $urandom_range(0, 2);
    while (nv < target) begin
      v = ($urandom_range(1, 100) <= pct);
      smp_q.push_back(3'($urandom));
      vld_q.push_back(v);
      if (v) nv++;
    end
  endtask

  // driver: start a window, play the stream, stop at res_vld or after a bounded wait
  task automatic run_window(input int len, input bit rand_start);
    start = 1'b1;
    window_len = WIN_W'(len);
    sample_vld = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    done_j = -1;
    busy_seen = 0;
    for (int j = 0; j < smp_q.size() + 20; j++) begin
      if (busy) busy_seen = 1;
      if (res_vld) begin
        done_j = j;
        break;
      end
      if (j < smp_q.size()) begin
        {d0, e0, f0} = smp_q[j];
        sample_vld = vld_q[j];
      end else begin
        {d0, e0, f0} = 3'($urandom);
        sample_vld = 1'b0;
      end
      if (rand_start && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        window_len = WIN_W'($urandom_range(0, 30));
      end else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    sample_vld = 1'b0;
  endtask

  task automatic accept();
    res_rdy = 1'b1;
    @(posedge clk); #1;
    res_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; window_len = '0; sample_vld = 1'b0; d0 = 1'b0; e0 = 1'b0; f0 = 1'b0; res_rdy = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b0 || res_vld !== 1'b0 || busy2 !== 1'b0 || res_vld2 !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b vld=%b exp 0/0", busy, res_vld);
    end
    checks++;
    if (tog_total !== '0 || {tog_d0, tog_e0, tog_f0} !== '0 || tog2_total !== '0) begin
      errors++; $display("FAIL reset_counts got %h/%0d exp 0", {tog_d0, tog_e0, tog_f0}, tog_total);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || res_vld !== 1'b0) begin
      errors++; $display("FAIL reset_idle got busy=%b vld=%b exp 0/0", busy, res_vld);
    end
  endtask

  task automatic test_directed();
    logic [3*CNT_W-1:0] e_m;
    smp_q = '{3'b000, 3'b111, 3'b111, 3'b010, 3'b101};
    vld_q = '{1, 1, 1, 1, 1};
    predict(4);
    run_window(4, 0);
    e_m = exp_q.pop_front();
    checks++;
    if ({tog_d0, tog_e0, tog_f0} !== e_m || tog_total !== (CNT_W+2)'(exp_tot)) begin
      errors++; $display("FAIL directed_counts got %h/%0d exp %h/%0d", {tog_d0, tog_e0, tog_f0}, tog_total, e_m, exp_tot);
    end
    checks++;
    if ({tog2_d0, tog2_e0, tog2_f0} !== exp_w2 || tog2_total !== (CNT_W2+2)'(exp_tot2)) begin
      errors++; $display("FAIL directed_w2 got %h/%0d exp %h/%0d", {tog2_d0, tog2_e0, tog2_f0}, tog2_total, exp_w2, exp_tot2);
    end
    checks++;
    if (done_j !== exp_done || res_vld2 !== 1'b1) begin
      errors++; $display("FAIL directed_latency got %0d exp %0d", done_j, exp_done);
    end
    accept();
  endtask

  task automatic test_zero_len();
    smp_q = '{3'b101, 3'b010};
    vld_q = '{1, 1};
    predict(0);
    run_window(0, 0);
    void'(exp_q.pop_front());
    checks++;
    if (done_j !== 0 || busy_seen !== 1'b0) begin
      errors++; $display("FAIL zero_len_timing got done=%0d busy_seen=%0d exp 0/0", done_j, busy_seen);
    end
    checks++;
    if (tog_total !== '0 || {tog_d0, tog_e0, tog_f0} !== '0 || tog2_total !== '0) begin
      errors++; $display("FAIL zero_len_counts got %h/%0d exp 0", {tog_d0, tog_e0, tog_f0}, tog_total);
    end
    accept();
  endtask

  task automatic test_gaps();
    logic [3*CNT_W-1:0] e_m;
    bit pat[7];
    bit dval;
    pat = '{1, 0, 0, 1, 0, 1, 1};
    smp_q.delete();
    vld_q.delete();
    dval = 1'b0;
    for (int k = 0; k < 7; k++) begin
      smp_q.push_back(pat[k] ? {dval, 2'($urandom)} : 3'($urandom));
      vld_q.push_back(pat[k]);
      if (pat[k]) dval = ~dval;
    end
    predict(3);
    run_window(3, 1);
    e_m = exp_q.pop_front();
    checks++;
    if ({tog_d0, tog_e0, tog_f0} !== e_m || tog_total !== (CNT_W+2)'(exp_tot) || tog_d0 !== CNT_W'(3)) begin
      errors++; $display("FAIL gaps_counts got %h/%0d exp %h/%0d", {tog_d0, tog_e0, tog_f0}, tog_total, e_m, exp_tot);
    end
    checks++;
    if (done_j !== exp_done) begin
      errors++; $display("FAIL gaps_latency got %0d exp %0d", done_j, exp_done);
    end
    accept();
  endtask

  task automatic test_hold();
    logic [3*CNT_W-1:0] e_m;
    gen_stream(5, 80);
    predict(5);
    run_window(5, 0);
    e_m = exp_q.pop_front();
    checks++;
    if (done_j !== exp_done) begin
      errors++; $display("FAIL hold_latency got %0d exp %0d", done_j, exp_done);
    end
    for (int c = 0; c < 5; c++) begin
      res_rdy = 1'b0;
      start = (c == 1 || c == 3);
      window_len = WIN_W'(7);
      sample_vld = 1'b1;
      {d0, e0, f0} = 3'($urandom);
      @(posedge clk); #1;
      checks++;
      if (res_vld !== 1'b1 || busy !== 1'b0 || {tog_d0, tog_e0, tog_f0} !== e_m || tog_total !== (CNT_W+2)'(exp_tot)) begin
        errors++; $display("FAIL hold_stable c=%0d got vld=%b %h exp vld=1 %h", c, res_vld, {tog_d0, tog_e0, tog_f0}, e_m);
      end
    end
    start = 1'b1;
    res_rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    res_rdy = 1'b0;
    sample_vld = 1'b0;
    checks++;
    if (res_vld !== 1'b0 || busy !== 1'b0 || {tog_d0, tog_e0, tog_f0} !== e_m) begin
      errors++; $display("FAIL hold_accept got vld=%b busy=%b %h exp 0/0 %h", res_vld, busy, {tog_d0, tog_e0, tog_f0}, e_m);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || res_vld !== 1'b0) begin
      errors++; $display("FAIL hold_coincident_start got busy=%b vld=%b exp 0/0", busy, res_vld);
    end
  endtask

  task automatic test_reset_mid();
    logic [3*CNT_W-1:0] e_m;
    bit seen;
    start = 1'b1;
    window_len = WIN_W'(8);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample_vld = 1'b1;
      {d0, e0, f0} = (k == 1) ? 3'b111 : 3'b000;
      @(posedge clk); #1;
    end
    sample_vld = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || res_vld !== 1'b0 || tog_total !== '0 || {tog_d0, tog_e0, tog_f0} !== '0) begin
      errors++; $display("FAIL reset_mid got busy=%b vld=%b total=%0d exp 0/0/0", busy, res_vld, tog_total);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      sample_vld = 1'b1;
      {d0, e0, f0} = 3'($urandom);
      @(posedge clk); #1;
      if (res_vld || busy) seen = 1;
    end
    sample_vld = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_mid_no_result got active=%0d exp 0", seen);
    end
    gen_stream(6, 70);
    predict(6);
    run_window(6, 1);
    e_m = exp_q.pop_front();
    checks++;
    if ({tog_d0, tog_e0, tog_f0} !== e_m || done_j !== exp_done) begin
      errors++; $display("FAIL reset_mid_fresh got %h done=%0d exp %h done=%0d", {tog_d0, tog_e0, tog_f0}, done_j, e_m, exp_done);
    end
    accept();
  endtask

  task automatic test_wrap();
    logic [3*CNT_W-1:0] e_m;
    smp_q.delete();
    vld_q.delete();
    for (int k = 0; k < 7; k++) begin
      smp_q.push_back({k[0], 2'b00});
      vld_q.push_back(1'b1);
    end
    predict(6);
    run_window(6, 0);
    e_m = exp_q.pop_front();
    checks++;
    if ({tog_d0, tog_e0, tog_f0} !== e_m || tog_d0 !== CNT_W'(6)) begin
      errors++; $display("FAIL wrap_main got %h exp %h", {tog_d0, tog_e0, tog_f0}, e_m);
    end
    checks++;
    if ({tog2_d0, tog2_e0, tog2_f0} !== exp_w2 || tog2_total !== (CNT_W2+2)'(exp_tot2)) begin
      errors++; $display("FAIL wrap_w2 got %h/%0d exp %h/%0d", {tog2_d0, tog2_e0, tog2_f0}, tog2_total, exp_w2, exp_tot2);
    end
`ifdef TOGGLE_SAT_EN
    checks++;
    if (sat_flag !== 1'b0 || sat_flag2 !== exp_sat2) begin
      errors++; $display("FAIL wrap_sat got %b/%b exp 0/%b", sat_flag, sat_flag2, exp_sat2);
    end
`endif
    accept();
  endtask

  task automatic test_random();
    logic [3*CNT_W-1:0] e_m;
    int len;
    int dly;
    for (int w = 0; w < 14; w++) begin
      len = $urandom_range(0, 20);
      gen_stream(len, 70);
      predict(len);
      run_window(len, 1);
      e_m = exp_q.pop_front();
      checks++;
      if ({tog_d0, tog_e0, tog_f0} !== e_m || tog_total !== (CNT_W+2)'(exp_tot)) begin
        errors++; $display("FAIL rand_counts w=%0d got %h/%0d exp %h/%0d", w, {tog_d0, tog_e0, tog_f0}, tog_total, e_m, exp_tot);
      end
      checks++;
      if ({tog2_d0, tog2_e0, tog2_f0} !== exp_w2 || tog2_total !== (CNT_W2+2)'(exp_tot2)) begin
        errors++; $display("FAIL rand_w2 w=%0d got %h/%0d exp %h/%0d", w, {tog2_d0, tog2_e0, tog2_f0}, tog2_total, exp_w2, exp_tot2);
      end
      checks++;
      if (done_j !== exp_done || busy_seen !== (len != 0)) begin
        errors++; $display("FAIL rand_timing w=%0d got done=%0d busy_seen=%0d exp %0d/%0d", w, done_j, busy_seen, exp_done, len != 0);
      end
`ifdef TOGGLE_SAT_EN
      checks++;
      if (sat_flag !== 1'b0 || sat_flag2 !== exp_sat2) begin
        errors++; $display("FAIL rand_sat w=%0d got %b/%b exp 0/%b", w, sat_flag, sat_flag2, exp_sat2);
      end
`endif
      dly = $urandom_range(0, 3);
      for (int c = 0; c < dly; c++) begin
        start = $urandom_range(0, 1);
        @(posedge clk); #1;
      end
      start = 1'b0;
      accept();
      checks++;
      if (res_vld !== 1'b0 || busy !== 1'b0 || {tog_d0, tog_e0, tog_f0} !== e_m) begin
        errors++; $display("FAIL rand_accept w=%0d got vld=%b busy=%b %h exp 0/0 %h", w, res_vld, busy, {tog_d0, tog_e0, tog_f0}, e_m);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_zero_len();
    test_gaps();
    test_hold();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
